// File: rtl/fp_pkg.sv
// Shared constants and the stage-1 payload type for the single-precision
// multiplier normalise/round back end.
package fp_pkg;

  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          EXP_MAX = 255;

  // InputExc bit positions: {any, ANaN, BNaN, AInf, BInf}
  localparam int EXC_ANY  = 4;
  localparam int EXC_ANAN = 3;
  localparam int EXC_BNAN = 2;
  localparam int EXC_AINF = 1;
  localparam int EXC_BINF = 0;

  // Flags bit positions: {NaN, Inf, Overflow, Underflow}
  localparam int FLG_NAN = 3;
  localparam int FLG_INF = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  typedef struct packed {
    logic              s;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic              g;
    logic              st;
    logic              zero;
    logic [4:0]        exc;
  } norm_t;

endpackage

// File: rtl/fp_round_pack.sv
// Stage-2 combinational logic: round-to-nearest-even on the normalised
// mantissa, then select the packed result and flags by exception priority.
module fp_round_pack
  import fp_pkg::*;
(
  input  norm_t       norm,
  output logic [31:0] z,
  output logic [3:0]  flags
);

  localparam logic signed [9:0] E_MAX = 10'(EXP_MAX);

  // Returns {carry, mantissa}; on carry the mantissa bits are already zero.
  function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic st);
    return {1'b0, m} + {23'd0, g & (st | m[0])};
  endfunction

  logic [23:0]       m_sum;
  logic signed [9:0] e_rnd;
  logic              exc_any;
  logic              is_nan;
  logic              is_inf;

  assign m_sum   = round_rne(norm.m, norm.g, norm.st);
  assign e_rnd   = norm.e + $signed({9'd0, m_sum[23]});
  assign exc_any = norm.exc[EXC_ANY] | (|norm.exc[3:0]);
  assign is_nan  = exc_any & (norm.exc[EXC_ANAN] | norm.exc[EXC_BNAN]);
  assign is_inf  = exc_any & (norm.exc[EXC_AINF] | norm.exc[EXC_BINF]);

  always_comb begin
    z     = {norm.s, e_rnd[7:0], m_sum[22:0]};
    flags = '0;
    if (is_nan || (is_inf && norm.zero)) begin
      z              = QNAN;
      flags[FLG_NAN] = 1'b1;
    end else if (is_inf) begin
      z              = {norm.s, 8'hFF, 23'd0};
      flags[FLG_INF] = 1'b1;
    end else if (norm.zero) begin
      z = {norm.s, 31'd0};
    end else if (e_rnd >= E_MAX) begin
      z              = {norm.s, 8'hFF, 23'd0};
      flags[FLG_INF] = 1'b1;
      flags[FLG_OVF] = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      z              = {norm.s, 31'd0};
      flags[FLG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_norm_round.sv
// Two-stage elastic back end of the single-precision multiplier:
// stage 1 normalises the 48-bit product, stage 2 rounds and packs.
module fp_mult_norm_round
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Sa,
  input  logic        Sb,
  input  logic [7:0]  Ea,
  input  logic [7:0]  Eb,
  input  logic [47:0] Mp,
  input  logic [4:0]  InputExc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Z,
  output logic [3:0]  Flags
);

  logic [1:0]        rst_sync_q;
  logic              rst_sync;
  logic signed [9:0] e_sum;
  norm_t             norm_d;
  norm_t             norm_p1;
  logic              vld_p1;
  logic              vld_p2;
  logic              ld_p2;
  logic [31:0]       z_d;
  logic [3:0]        flags_d;
  logic [31:0]       z_p2;
  logic [3:0]        flags_p2;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync = rst_sync_q[1];

  assign ld_p2    = out_ready | ~vld_p2;
  assign in_ready = rst_sync & (~vld_p1 | ld_p2);

  // Stage 0 -> 1: normalise
  assign e_sum = 10'($signed({2'b00, Ea}) + $signed({2'b00, Eb}) - BIAS);

  always_comb begin
    norm_d.s    = Sa ^ Sb;
    norm_d.zero = (Ea == 8'd0) | (Eb == 8'd0);
    norm_d.exc  = InputExc;
    if (Mp[47]) begin
      norm_d.m  = Mp[46:24];
      norm_d.g  = Mp[23];
      norm_d.st = |Mp[22:0];
      norm_d.e  = e_sum + 10'sd1;
    end else begin
      norm_d.m  = Mp[45:23];
      norm_d.g  = Mp[22];
      norm_d.st = |Mp[21:0];
      norm_d.e  = e_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) norm_p1 <= norm_d;
  end

  // Stage 1 -> 2: round and pack
  fp_round_pack u_round_pack (
    .norm  (norm_p1),
    .z     (z_d),
    .flags (flags_d)
  );

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      z_p2     <= '0;
      flags_p2 <= '0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (ld_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          z_p2     <= z_d;
          flags_p2 <= flags_d;
        end
      end
    end
  end

  assign out_valid = vld_p2;
  assign Z         = z_p2;
  assign Flags     = flags_p2;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Bench for fp_mult_norm_round: directed vector table, back-pressure and
// reset sequences, and randomized streams against an arithmetic reference.
module tb_fp_mult_norm_round;

  typedef struct {
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] mp;
    logic [4:0]  exc;
    logic [31:0] z;
    logic [3:0]  f;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Sa, Sb;
  logic [7:0]  Ea, Eb;
  logic [47:0] Mp;
  logic [4:0]  InputExc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic [3:0]  Flags;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];

  fp_mult_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sa(Sa), .Sb(Sb), .Ea(Ea), .Eb(Eb), .Mp(Mp), .InputExc(InputExc),
    .out_valid(out_valid), .out_ready(out_ready), .Z(Z), .Flags(Flags)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Sa = v.sa; Sb = v.sb; Ea = v.ea; Eb = v.eb; Mp = v.mp; InputExc = v.exc;
  endtask

  // Reference: value view of the product, rounding by remainder vs. half-ulp.
  function automatic void ref_model(input vec_t v, output logic [31:0] z, output logic [3:0] f);
    longint unsigned p, q, rem, half;
    int  e, sh;
    logic s, zero, nan, inf;
    p    = 64'(v.mp);
    s    = v.sa ^ v.sb;
    zero = (v.ea == 8'd0) || (v.eb == 8'd0);
    nan  = v.exc[3] | v.exc[2];
    inf  = v.exc[1] | v.exc[0];
    sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
    e    = int'(v.ea) + int'(v.eb) - 127 + (sh - 23);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (nan || (inf && zero)) begin z = 32'h7FC0_0000;        f = 4'b1000; end
    else if (inf)             begin z = {s, 8'hFF, 23'd0};    f = 4'b0100; end
    else if (zero)            begin z = {s, 31'd0};           f = 4'b0000; end
    else if (e >= 255)        begin z = {s, 8'hFF, 23'd0};    f = 4'b0110; end
    else if (e <= 0)          begin z = {s, 31'd0};           f = 4'b0001; end
    else begin
      z = {s, 8'(e), 23'(q - (64'd1 << 23))};
      f = 4'b0000;
    end
  endfunction

  function automatic vec_t rand_beat();
    vec_t v;
    logic [22:0] ma, mb;
    ma = 23'($urandom);
    mb = 23'($urandom);
    v.sa  = 1'($urandom);
    v.sb  = 1'($urandom);
    v.ea  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
    v.eb  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
    v.mp  = 48'({1'b1, ma}) * 48'({1'b1, mb});
    v.exc = ($urandom_range(0, 7) == 0) ? {1'b1, 4'($urandom_range(1, 15))} : 5'd0;
    v.z   = '0;
    v.f   = '0;
    return v;
  endfunction

  // Single beat into an empty pipe; checks 2-cycle latency and the result.
  task automatic run_one(input vec_t v, input string tag);
    int w = 0;
    int lat = 1;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_z"}, Z, v.z);
    chk({tag, "_flags"}, 32'(Flags), 32'(v.f));
  endtask

  // mode 0: random valid/ready; mode 1: steady input, out_ready low for 4 cycles.
  task automatic stream(input int n, input int mode);
    vec_t        b[$];
    logic [31:0] ez[$];
    logic [3:0]  ef[$];
    logic [31:0] z_e, hz;
    logic [3:0]  f_e;
    int sent = 0, got = 0, cyc = 0, stall_at = -1;
    logic held = 1'b0;
    for (int i = 0; i < n; i++) begin
      b.push_back(rand_beat());
      ref_model(b[i], z_e, f_e);
      ez.push_back(z_e);
      ef.push_back(f_e);
    end
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_z", Z, hz);
      end
      if (sent < n) begin
        drive(b[sent]);
        in_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (mode == 1) ? (cyc >= 4) : ($urandom_range(0, 2) != 0);
      #1;
      if (mode == 1 && in_valid && !in_ready && stall_at < 0) stall_at = sent;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("stream_z", Z, ez[got]);
        chk("stream_flags", 32'(Flags), 32'(ef[got]));
        got++;
      end
      held = out_valid && !out_ready;
      hz   = Z;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'(n));
    if (mode == 1) chk("bp_accepted_before_stall", 32'(stall_at), 32'd2);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Sa = 1'b0; Sb = 1'b0; Ea = '0; Eb = '0; Mp = '0; InputExc = '0;

    tbl.push_back('{1'b0, 1'b0, 8'h7F, 8'h80, 48'h6000_0000_0000, 5'h00, 32'h4040_0000, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h7F, 8'h7F, 48'h4000_0040_0000, 5'h00, 32'h3F80_0000, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h7F, 8'h7F, 48'h4000_00C0_0000, 5'h00, 32'h3F80_0002, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h7F, 8'h7F, 48'h7FFF_FFC0_0000, 5'h00, 32'h4000_0000, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 8'h7F, 8'h7F, 48'h8000_0000_0000, 5'h00, 32'hC000_0000, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h7F, 8'h7F, 48'h8000_0180_0000, 5'h00, 32'h4000_0002, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'hFE, 8'hFE, 48'h4000_0000_0000, 5'h00, 32'h7F80_0000, 4'h6});
    tbl.push_back('{1'b1, 1'b0, 8'hFE, 8'hFE, 48'h4000_0000_0000, 5'h00, 32'hFF80_0000, 4'h6});
    tbl.push_back('{1'b0, 1'b0, 8'h01, 8'h01, 48'h4000_0000_0000, 5'h00, 32'h0000_0000, 4'h1});
    tbl.push_back('{1'b1, 1'b0, 8'h40, 8'h3F, 48'h4000_0000_0000, 5'h00, 32'h8000_0000, 4'h1});
    tbl.push_back('{1'b0, 1'b0, 8'h40, 8'h40, 48'h4000_0000_0000, 5'h00, 32'h0080_0000, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'hFE, 8'h7F, 48'h4000_0000_0000, 5'h00, 32'h7F00_0000, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'hFE, 8'h7F, 48'h8000_0000_0000, 5'h00, 32'h7F80_0000, 4'h6});
    tbl.push_back('{1'b0, 1'b0, 8'hFE, 8'h7F, 48'h7FFF_FFC0_0000, 5'h00, 32'h7F80_0000, 4'h6});
    tbl.push_back('{1'b0, 1'b0, 8'h7F, 8'h00, 48'h4000_0000_0000, 5'h12, 32'h7FC0_0000, 4'h8});
    tbl.push_back('{1'b1, 1'b0, 8'hFF, 8'h80, 48'h4000_0000_0000, 5'h12, 32'hFF80_0000, 4'h4});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 8'h7F, 48'h4000_0000_0000, 5'h18, 32'h7FC0_0000, 4'h8});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 8'hFF, 48'h4000_0000_0000, 5'h13, 32'h7F80_0000, 4'h4});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 8'h80, 48'h4000_0000_0000, 5'h00, 32'h8000_0000, 4'h0});

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_z", Z, 32'd0);
    chk("reset_flags", 32'(Flags), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_one(tbl[i], $sformatf("tbl%0d", i));

    stream(5, 1);

    // Fill both stages, then reset mid-cycle.
    @(negedge clk);
    out_ready = 1'b0;
    drive(tbl[1]);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("prefill_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_z", Z, 32'd0);
    chk("async_reset_flags", 32'(Flags), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_one(tbl[0], "post_reset");
    @(negedge clk);
    chk("post_reset_drained", 32'(out_valid), 32'd0);

    stream(300, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
